// File: rtl/instruction_fetch_unit.sv
// Fetch stage: pulls one instruction word at a time from instruction memory over req/ack
// and writes it into the instruction register, sequenced by the decoder's next/halt/jump.
module instruction_fetch_unit #(
    parameter int unsigned    IW       = 17,
    parameter int unsigned    AW       = 8,
    parameter logic [AW-1:0]  PC_RESET = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic          ir_write,
    output logic [IW-1:0] ir_data,
    input  logic          next,
    input  logic          halt,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          req_q, wr_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_RESET;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_LOAD;
                    ir_d    = imem_data;
                    pc_d    = pc_q + AW'(1);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                // halt outranks jump when both accompany next
                if (next) begin
                    if (halt) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        if (jump) begin
                            pc_d = jump_addr;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            req_q   <= (state_d == S_FETCH);
            wr_q    <= (state_d == S_LOAD);
            busy_q  <= (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_WAIT);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ir_write  = wr_q;
    assign ir_data   = ir_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized
// program run compared against a transaction-level model of pc, fetch count and IR contents.
module tb_instruction_fetch_unit;

    localparam int unsigned IW = 17;
    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] PC_RESET = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_data;
    logic          ir_write;
    logic [IW-1:0] ir_data;
    logic          next;
    logic          halt;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [15:0]   fetch_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: program counter, fetch count and last fetched word.
    logic [AW-1:0] m_pc;
    int            m_cnt;
    logic [IW-1:0] m_ir;

    instruction_fetch_unit #(.IW(IW), .AW(AW), .PC_RESET(PC_RESET)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir_write  (ir_write),
        .ir_data   (ir_data),
        .next      (next),
        .halt      (halt),
        .jump      (jump),
        .jump_addr (jump_addr),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_start();
        m_pc  = PC_RESET;
        m_cnt = 0;
    endfunction

    function automatic void model_fetch(input logic [IW-1:0] w);
        m_ir  = w;
        m_pc  = AW'((int'(m_pc) + 1) % (1 << AW));
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    endfunction

    // Serves one fetch: waits (bounded) for a request, stalls `dly` cycles, then acks.
    // Returns the address seen with the ack and the IR strobe/data in the following cycle.
    task automatic serve_fetch(input int unsigned dly, input logic [IW-1:0] w,
                               output logic [AW-1:0] addr, output logic wrote,
                               output logic [IW-1:0] data, output logic ok);
        int unsigned n = 0;
        ok = 1'b1;
        wrote = 1'b0;
        data = '0;
        addr = '0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (imem_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < int'(dly); i++) step();
        addr = imem_addr;
        imem_ack = 1'b1;
        imem_data = w;
        step();
        imem_ack = 1'b0;
        imem_data = IW'($urandom);
        wrote = ir_write;
        data = ir_data;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({imem_req, ir_write, busy, done} !== 4'b0000 || pc !== PC_RESET ||
            ir_data !== '0 || fetch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b wr=%b busy=%b done=%b pc=%h ir=%h cnt=%0d, required all zero",
                     imem_req, ir_write, busy, done, pc, ir_data, fetch_cnt);
        end
        #2 rst = 1'b1;
        step();
        imem_ack = 1'b1;
        next = 1'b1;
        step();
        imem_ack = 1'b0;
        next = 1'b0;
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || pc !== PC_RESET || ir_data !== '0) begin
            errors++;
            $display("FAIL idle_spurious: busy=%b req=%b pc=%h ir=%h, required idle with reset values",
                     busy, imem_req, pc, ir_data);
        end
    endtask

    task automatic test_first_fetch();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00 || ir_write !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h wr=%b busy=%b, required 1 00 0 1",
                     imem_req, imem_addr, ir_write, busy);
        end
        imem_ack = 1'b1;
        imem_data = 17'h00024;
        step();
        imem_ack = 1'b0;
        model_fetch(17'h00024);
        checks++;
        if (ir_write !== 1'b1 || ir_data !== 17'h00024 || pc !== m_pc || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL first_write: wr=%b ir=%h pc=%h cnt=%0d, required 1 %h %h %0d",
                     ir_write, ir_data, pc, fetch_cnt, m_ir, m_pc, m_cnt);
        end
        step();
        checks++;
        if (ir_write !== 1'b0 || imem_req !== 1'b0 || busy !== 1'b1 || ir_data !== m_ir) begin
            errors++;
            $display("FAIL wait_entry: wr=%b req=%b busy=%b ir=%h, required 0 0 1 %h",
                     ir_write, imem_req, busy, ir_data, m_ir);
        end
    endtask

    task automatic test_ack_delay();
        logic [AW-1:0] a0;
        logic [IW-1:0] w;
        next = 1'b1;
        step();
        next = 1'b0;
        a0 = imem_addr;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || ir_write !== 1'b0 || pc !== m_pc || a0 !== m_pc) begin
                errors++;
                $display("FAIL ack_stall: cyc=%0d req=%b addr=%h wr=%b pc=%h, required 1 %h 0 %h",
                         i, imem_req, imem_addr, ir_write, pc, m_pc, m_pc);
            end
            step();
        end
        w = IW'($urandom);
        imem_ack = 1'b1;
        imem_data = w;
        step();
        imem_ack = 1'b0;
        model_fetch(w);
        checks++;
        if (ir_write !== 1'b1 || ir_data !== w || pc !== m_pc || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL ack_late: wr=%b ir=%h pc=%h cnt=%0d, required 1 %h %h %0d",
                     ir_write, ir_data, pc, fetch_cnt, w, m_pc, m_cnt);
        end
        step();
    endtask

    task automatic test_jump_halt();
        logic [AW-1:0] a;
        logic wr, ok;
        logic [IW-1:0] d, w;
        next = 1'b1;
        jump = 1'b1;
        jump_addr = 8'h40;
        step();
        next = 1'b0;
        jump = 1'b0;
        m_pc = 8'h40;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL jump_addr: req=%b addr=%h, required 1 40", imem_req, imem_addr);
        end
        w = IW'($urandom);
        serve_fetch(0, w, a, wr, d, ok);
        model_fetch(w);
        checks++;
        if (!ok || wr !== 1'b1 || d !== w || pc !== m_pc) begin
            errors++;
            $display("FAIL jump_fetch: ok=%b wr=%b ir=%h pc=%h, required 1 1 %h %h", ok, wr, d, pc, w, m_pc);
        end
        next = 1'b1;
        jump = 1'b1;
        halt = 1'b1;
        jump_addr = 8'h99;
        step();
        next = 1'b0;
        jump = 1'b0;
        halt = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== m_pc || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_done: done=%b busy=%b pc=%h req=%b, required 1 0 %h 0", done, busy, pc, imem_req, m_pc);
        end
        next = 1'b1;
        jump = 1'b1;
        imem_ack = 1'b1;
        step();
        step();
        next = 1'b0;
        jump = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || pc !== m_pc || ir_data !== m_ir || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL done_frozen: done=%b pc=%h ir=%h cnt=%0d, required 1 %h %h %0d",
                     done, pc, ir_data, fetch_cnt, m_pc, m_ir, m_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        logic wr, ok;
        logic [IW-1:0] d, w;
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
        w = IW'($urandom);
        serve_fetch(1, w, a, wr, d, ok);
        model_fetch(w);
        next = 1'b1;
        jump = 1'b1;
        jump_addr = 8'hFF;
        step();
        next = 1'b0;
        jump = 1'b0;
        m_pc = 8'hFF;
        w = IW'($urandom);
        serve_fetch(0, w, a, wr, d, ok);
        model_fetch(w);
        checks++;
        if (!ok || a !== 8'hFF || pc !== m_pc || pc !== 8'h00 || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL pc_wrap: ok=%b addr=%h pc=%h cnt=%0d, required 1 ff %h %0d", ok, a, pc, fetch_cnt, m_pc, m_cnt);
        end
    endtask

    task automatic test_spurious();
        logic [AW-1:0] p0;
        p0 = pc;
        imem_ack = 1'b1;
        imem_data = IW'($urandom);
        start = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || imem_req !== 1'b0 || ir_write !== 1'b0 || pc !== p0 ||
            ir_data !== m_ir || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL wait_spurious: busy=%b req=%b wr=%b pc=%h ir=%h cnt=%0d, required 1 0 0 %h %h %0d",
                     busy, imem_req, ir_write, pc, ir_data, fetch_cnt, p0, m_ir, m_cnt);
        end
        next = 1'b1;
        step();
        next = 1'b0;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL start_busy: req=%b addr=%h cnt=%0d, required 1 %h %0d", imem_req, imem_addr, fetch_cnt, m_pc, m_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] a;
        logic wr, ok;
        logic [IW-1:0] d, w;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, ir_write, busy, done} !== 4'b0000 || pc !== PC_RESET ||
            ir_data !== '0 || fetch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: req=%b wr=%b busy=%b done=%b pc=%h ir=%h cnt=%0d, required all zero",
                     imem_req, ir_write, busy, done, pc, ir_data, fetch_cnt);
        end
        step();
        #2 rst = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
        w = IW'($urandom);
        serve_fetch(0, w, a, wr, d, ok);
        model_fetch(w);
        checks++;
        if (!ok || a !== PC_RESET || wr !== 1'b1 || d !== w || pc !== m_pc || fetch_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rerun: ok=%b addr=%h wr=%b ir=%h pc=%h cnt=%0d, required 1 %h 1 %h %h 1",
                     ok, a, wr, d, pc, fetch_cnt, PC_RESET, w, m_pc);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, exp_a;
        logic wr, ok;
        logic [IW-1:0] d, w;
        int unsigned dly;
        next = 1'b1;
        halt = 1'b1;
        step();
        next = 1'b0;
        halt = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
        for (int i = 0; i < 150; i++) begin
            w = IW'($urandom);
            dly = $urandom_range(0, 3);
            exp_a = m_pc;
            serve_fetch(dly, w, a, wr, d, ok);
            model_fetch(w);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rnd_timeout: iter=%0d no request within bound", i);
                return;
            end
            checks++;
            if (a !== exp_a || wr !== 1'b1 || d !== w) begin
                errors++;
                $display("FAIL rnd_fetch: iter=%0d addr=%h wr=%b ir=%h, required %h 1 %h", i, a, wr, d, exp_a, w);
            end
            checks++;
            if (pc !== m_pc || fetch_cnt !== 16'(m_cnt) || ir_data !== m_ir) begin
                errors++;
                $display("FAIL rnd_state: iter=%0d pc=%h cnt=%0d ir=%h, required %h %0d %h",
                         i, pc, fetch_cnt, ir_data, m_pc, m_cnt, m_ir);
            end
            repeat ($urandom_range(0, 2)) begin
                imem_ack = 1'($urandom);
                step();
            end
            imem_ack = 1'b0;
            next = 1'b1;
            jump = ($urandom_range(0, 3) == 0);
            jump_addr = AW'($urandom);
            halt = (i == 149);
            step();
            if (!halt && jump) m_pc = jump_addr;
            next = 1'b0;
            jump = 1'b0;
            halt = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || pc !== m_pc || fetch_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL rnd_end: done=%b pc=%h cnt=%0d, required 1 %h %0d", done, pc, fetch_cnt, m_pc, m_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        imem_ack = 1'b0;
        imem_data = '0;
        next = 1'b0;
        halt = 1'b0;
        jump = 1'b0;
        jump_addr = '0;
        m_pc = PC_RESET;
        m_cnt = 0;
        m_ir = '0;
        test_reset();
        test_first_fetch();
        test_ack_delay();
        test_jump_halt();
        test_wrap();
        test_spurious();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
